// File: rtl/sequential_divider.sv
// Iterative restoring divider: one quotient bit per clock with a start/done handshake.
// Optional two's-complement operation is enabled by defining SEQUENTIAL_DIVIDER_SIGNED_EN.
module sequential_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic             r_zero;

    logic [WIDTH:0]   w_rem_q;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_accept;
    logic             w_dsr_zero;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic [WIDTH-1:0] w_quo_res;
    logic [WIDTH-1:0] w_rem_res;

    // Partial remainder is one bit wider than the operands so the compare cannot overflow.
    assign w_rem_q    = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge       = (w_rem_q >= {1'b0, r_dsr});
    assign w_rem_next = w_ge ? WIDTH'(w_rem_q - {1'b0, r_dsr}) : w_rem_q[WIDTH-1:0];
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_FINISH));
    assign w_dsr_zero = (divisor == {WIDTH{1'b0}});

`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign w_dvd_mag = dividend[WIDTH-1] ? neg_f(dividend) : dividend;
    assign w_dsr_mag = divisor[WIDTH-1]  ? neg_f(divisor)  : divisor;
    assign w_quo_res = r_neg_q ? neg_f(r_quo) : r_quo;
    assign w_rem_res = r_neg_r ? neg_f(r_rem) : r_rem;

    // Result signs are captured with the operands and applied during the FINISH load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_r <= dividend[WIDTH-1];
        end else begin
            r_neg_q <= r_neg_q;
            r_neg_r <= r_neg_r;
        end
    end
`else
    assign w_dvd_mag = dividend;
    assign w_dsr_mag = divisor;
    assign w_quo_res = r_quo;
    assign w_rem_res = r_rem;
`endif

    // Control FSM, shift/subtract datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= {CW{1'b0}};
            r_dvd       <= {WIDTH{1'b0}};
            r_dsr       <= {WIDTH{1'b0}};
            r_rem       <= {WIDTH{1'b0}};
            r_quo       <= {WIDTH{1'b0}};
            r_zero      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                S_RUN: begin
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    if (r_count == {CW{1'b0}}) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_FINISH: begin
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    // The zero-divide path never shifts r_dvd, so it still holds the raw dividend.
                    if (r_zero) begin
                        quotient    <= {WIDTH{1'b1}};
                        remainder   <= r_dvd;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= w_quo_res;
                        remainder   <= w_rem_res;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
            // Acceptance overrides the FINISH->IDLE step to allow back-to-back operation.
            if (w_accept) begin
                busy    <= 1'b1;
                r_count <= CW'(WIDTH - 1);
                r_rem   <= {WIDTH{1'b0}};
                r_quo   <= {WIDTH{1'b0}};
                r_zero  <= w_dsr_zero;
                r_dsr   <= w_dsr_mag;
                r_dvd   <= w_dsr_zero ? dividend : w_dvd_mag;
                r_state <= w_dsr_zero ? S_FINISH : S_RUN;
            end
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: scoreboard of expected results popped on done.
module tb_sequential_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   done_cycs[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   cyc = 0;

    sequential_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
            int sa = int'($signed(a));
            int sb_v = int'($signed(b));
            e.q = W'(sa / sb_v);
            e.r = W'(sa % sb_v);
`else
            e.q = a / b;
            e.r = a % b;
`endif
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            done_cycs.push_back(cyc);
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("quotient", 32'(quotient), 32'(e.q));
                check_eq("remainder", 32'(remainder), 32'(e.r));
                check_eq("div_by_zero", 32'(div_by_zero), 32'(e.z));
`ifndef SEQUENTIAL_DIVIDER_SIGNED_EN
                if (e.b != '0) begin
                    check_eq("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                    check_eq("rem_lt_div", 32'(remainder < e.b), 32'd1);
                end
`endif
            end
        end
    end

    // Drives one request for a cycle; returns the edge count of the accepting edge.
    task automatic issue_exp(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e,
                             output int t0);
        start = 1'b1;
        dividend = a;
        divisor = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
        dividend = W'($urandom);
        divisor = W'($urandom);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int t0);
        issue_exp(a, b, model(a, b), t0);
    endtask

    task automatic wait_done(input int n, input int budget);
        int target;
        target = n_done + n;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (n_done >= target) break;
        end
        #1;
        if (n_done < target) check_eq("done_timeout", 32'(n_done), 32'(target));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        int   t0;
        int   t1;
        int   base;
        int   order[256];
        exp_t e;

        idle(3);
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_q", 32'(quotient), 32'd0);
        check_eq("rst_r", 32'(remainder), 32'd0);
        check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // 13/3: busy through RUN and FINISH, done after edge WIDTH+1.
        done_cycs.delete();
        issue(4'd13, 4'd3, t0);
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            check_eq("t1_busy", 32'(busy), 32'd1);
            check_eq("t1_no_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_busy_end", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check_eq("t1_done_cnt", 32'(done_cycs.size()), 32'd1);
        if (done_cycs.size() > 0) check_eq("t1_latency", 32'(done_cycs[0] - t0), 32'(W + 1));
        idle(2);

        // 9/0 then 15/1 issued in the FINISH cycle.
        done_cycs.delete();
        issue(4'd9, 4'd0, t0);
        issue(4'd15, 4'd1, t1);
        wait_done(2, 20);
        check_eq("t2_done_cnt", 32'(done_cycs.size()), 32'd2);
        if (done_cycs.size() > 1) begin
            check_eq("t2_zlat", 32'(done_cycs[0] - t0), 32'd1);
            check_eq("t2_b2b_edge", 32'(t1 - t0), 32'd1);
            check_eq("t2_lat", 32'(done_cycs[1] - t1), 32'(W + 1));
        end
        idle(2);

        // 6/7 offered during a 13/3 RUN must be ignored.
        base = n_done;
        issue(4'd13, 4'd3, t0);
        start = 1'b1;
        dividend = 4'd6;
        divisor = 4'd7;
        idle(2);
        start = 1'b0;
        wait_done(1, 20);
        idle(6);
        check_eq("t3_one_done", 32'(n_done - base), 32'd1);

        // Reset at edge 2 of 12/5 aborts without done.
        issue(4'd12, 4'd5, t0);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        void'(sb.pop_back());
        base = n_done;
        @(negedge clk);
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_done", 32'(done), 32'd0);
        check_eq("t4_q", 32'(quotient), 32'd0);
        check_eq("t4_r", 32'(remainder), 32'd0);
        check_eq("t4_dbz", 32'(div_by_zero), 32'd0);
        idle(10);
        check_eq("t4_no_done", 32'(n_done - base), 32'd0);
        issue(4'd12, 4'd5, t0);
        wait_done(1, 20);
        idle(2);

`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
        e = '{a: 4'b1001, b: 4'd2, q: 4'b1101, r: 4'b1111, z: 1'b0};
        issue_exp(4'b1001, 4'd2, e, t0);
        wait_done(1, 20);
        e = '{a: 4'b1000, b: 4'b1111, q: 4'b1000, r: 4'd0, z: 1'b0};
        issue_exp(4'b1000, 4'b1111, e, t0);
        wait_done(1, 20);
        e = '{a: 4'd7, b: 4'b1110, q: 4'b1101, r: 4'd1, z: 1'b0};
        issue_exp(4'd7, 4'b1110, e, t0);
        wait_done(1, 20);
        idle(2);
`endif

        // Exhaustive sweep of all operand pairs in shuffled order.
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int tmp;
            j = int'($urandom_range(i, 0));
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            logic [7:0] p;
            p = 8'(order[i]);
            issue(p[7:4], p[3:0], t0);
            wait_done(1, 20);
        end

        idle(4);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
